pucch_ncs_hop_gen: RTL and testbench

Consumes the pseudo-random c-sequence word stream from the c-sequence generator control stage and assembles the per-symbol PUCCH cyclic-shift hopping values n_cs(n_s, l) = Σ_{m=0..7} 2^m · c(8·14·n_s + 8·l + m) for one slot (TS 38.211 §6.3.2.2.2). It sits between the c-sequence generator and the PUCCH sequence/phase-rotation stage. Per request, it:
- launches the generator with c_init = n_ID,
- discards the bits belonging to earlier slots,
- emits 14 bytes, one per OFDM symbol, over a valid/ready handshake.

---
 rtl/pucch_ncs_hop_gen.sv | 126 ++++++++++++
 tb/tb_pucch_ncs_hop_gen.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pucch_ncs_hop_gen.sv
// PUCCH cyclic-shift hopping generator: skips earlier-slot c-sequence bits and packs 8-bit n_cs per symbol.
// Optional alpha index output enabled by defining PUCCH_NCS_ALPHA_EN.
module pucch_ncs_hop_gen #(
  parameter int NGEN  = 2,
  parameter int NSYMB = 14
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic [9:0]      i_nid,
  input  logic [7:0]      i_slot,
  output logic            o_cseq_start,
  output logic [30:0]     o_cseq_init,
  output logic [15:0]     o_cseq_threshold,
  output logic            o_cseq_get,
  input  logic [NGEN-1:0] i_cseq_bit,
  input  logic            i_cseq_valid,
  output logic [7:0]      o_ncs,
  output logic [3:0]      o_sym,
  output logic            o_valid,
  input  logic            i_ready,
  output logic            o_busy,
`ifdef PUCCH_NCS_ALPHA_EN
  input  logic [3:0]      i_m0,
  input  logic [3:0]      i_mcs,
  output logic [3:0]      o_alpha_idx,
`endif
  output logic            o_done
);

  localparam int         SHIFT     = $clog2(NGEN);
  localparam int         WPB       = 8 / NGEN;
  localparam logic [2:0] LAST_WORD = 3'(WPB - 1);
  localparam logic [3:0] LAST_SYM  = 4'(NSYMB - 1);
  localparam logic [15:0] BITS_PER_SLOT = 16'(8 * NSYMB);

  typedef enum logic [2:0] {IDLE, LAUNCH, SKIP, COLLECT, DRAIN} state_t;

  state_t      state, state_nxt;
  logic [14:0] skip_words, skip_cnt;
  logic [2:0]  word_idx;
  logic [3:0]  sym_cnt;
  logic [7:0]  acc, byte_nxt;
  logic        xfer_in, xfer_out, byte_done;

  // Upstream ready is the only combinational output, and only COLLECT depends on i_ready.
  assign o_cseq_get = (state == SKIP) || ((state == COLLECT) && (!o_valid || i_ready));
  assign xfer_in    = i_cseq_valid && o_cseq_get;
  assign xfer_out   = o_valid && i_ready;
  assign byte_done  = (state == COLLECT) && xfer_in && (word_idx == LAST_WORD);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_nxt = state;
    byte_nxt  = acc;
    byte_nxt[word_idx*NGEN +: NGEN] = i_cseq_bit;
    case (state)
      IDLE:    if (i_start) state_nxt = LAUNCH;
      LAUNCH:  state_nxt = (skip_words != '0) ? SKIP : COLLECT;
      SKIP:    if (xfer_in && (skip_cnt == skip_words - 15'd1)) state_nxt = COLLECT;
      COLLECT: if (byte_done && (sym_cnt == LAST_SYM)) state_nxt = DRAIN;
      DRAIN:   if (xfer_out) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      o_cseq_start     <= 1'b0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
      o_cseq_init      <= '0;
      o_cseq_threshold <= '0;
      skip_words       <= '0;
      skip_cnt         <= '0;
      word_idx         <= '0;
      sym_cnt          <= '0;
      acc              <= '0;
      o_ncs            <= '0;
      o_sym            <= '0;
      o_valid          <= 1'b0;
`ifdef PUCCH_NCS_ALPHA_EN
      o_alpha_idx      <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments keep every register update order-independent within the edge.
      state        <= state_nxt;
      o_cseq_start <= (state_nxt == LAUNCH);
      o_busy       <= (state_nxt != IDLE);
      o_done       <= 1'b0;

      if ((state == IDLE) && i_start) begin
        o_cseq_init      <= {21'd0, i_nid};
        o_cseq_threshold <= (16'(i_slot) + 16'd1) * BITS_PER_SLOT;
        skip_words       <= 15'((16'(i_slot) * BITS_PER_SLOT) >> SHIFT);
        skip_cnt         <= '0;
        word_idx         <= '0;
        sym_cnt          <= '0;
      end

      if ((state == SKIP) && xfer_in) skip_cnt <= skip_cnt + 15'd1;

      if ((state == COLLECT) && xfer_in) begin
        acc      <= byte_nxt;
        word_idx <= (word_idx == LAST_WORD) ? 3'd0 : word_idx + 3'd1;
      end

      // A completing byte overwrites the output register even as the previous beat leaves.
      if (byte_done) begin
        o_ncs   <= byte_nxt;
        o_sym   <= sym_cnt;
        o_valid <= 1'b1;
        sym_cnt <= sym_cnt + 4'd1;
`ifdef PUCCH_NCS_ALPHA_EN
        o_alpha_idx <= 4'((9'(i_m0) + 9'(i_mcs) + 9'(byte_nxt)) % 9'd12);
`endif
      end else if (xfer_out) begin
        o_valid <= 1'b0;
      end

      if ((state == DRAIN) && xfer_out) o_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pucch_ncs_hop_gen.sv
// Directed bench for pucch_ncs_hop_gen: Gold-sequence upstream model feeding the DUT, expected n_cs from tables/model.
module tb_pucch_ncs_hop_gen;
  localparam int NGEN  = 2;
  localparam int NSYMB = 14;
  localparam int CLEN  = 1024;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            i_start = 1'b0;
  logic [9:0]      i_nid = '0;
  logic [7:0]      i_slot = '0;
  logic            o_cseq_start, o_cseq_get, o_valid, o_busy, o_done;
  logic [30:0]     o_cseq_init;
  logic [15:0]     o_cseq_threshold;
  logic [NGEN-1:0] i_cseq_bit = '0;
  logic            i_cseq_valid = 1'b1;
  logic [7:0]      o_ncs;
  logic [3:0]      o_sym;
  logic            i_ready = 1'b1;
`ifdef PUCCH_NCS_ALPHA_EN
  logic [3:0]      i_m0 = 4'd3;
  logic [3:0]      i_mcs = 4'd5;
  logic [3:0]      o_alpha_idx;
`endif

  int tests = 0;
  int fails = 0;

  bit cseq [0:CLEN-1];
  bit x1 [0:1600+CLEN+31];
  bit x2 [0:1600+CLEN+31];
  int up_ptr = 0;
  int up_words = 0;
  bit up_gap = 1'b0;

  int ncs_tbl [0:13] = '{239, 107, 223, 6, 24, 2, 3, 66, 238, 125, 209, 145, 44, 233};
  int alpha_tbl [0:13] = '{7, 7, 3, 2, 8, 10, 11, 2, 6, 1, 1, 9, 4, 1};

  pucch_ncs_hop_gen #(.NGEN(NGEN), .NSYMB(NSYMB)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_start          (i_start),
    .i_nid            (i_nid),
    .i_slot           (i_slot),
    .o_cseq_start     (o_cseq_start),
    .o_cseq_init      (o_cseq_init),
    .o_cseq_threshold (o_cseq_threshold),
    .o_cseq_get       (o_cseq_get),
    .i_cseq_bit       (i_cseq_bit),
    .i_cseq_valid     (i_cseq_valid),
    .o_ncs            (o_ncs),
    .o_sym            (o_sym),
    .o_valid          (o_valid),
    .i_ready          (i_ready),
    .o_busy           (o_busy),
`ifdef PUCCH_NCS_ALPHA_EN
    .i_m0             (i_m0),
    .i_mcs            (i_mcs),
    .o_alpha_idx      (o_alpha_idx),
`endif
    .o_done           (o_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Length-31 Gold sequence with Nc = 1600.
  task automatic gen_cseq(input logic [30:0] cinit);
    for (int n = 0; n < 31; n++) begin
      x1[n] = (n == 0);
      x2[n] = cinit[n];
    end
    for (int n = 0; n < 1600 + CLEN; n++) begin
      x1[n+31] = x1[n+3] ^ x1[n];
      x2[n+31] = x2[n+3] ^ x2[n+2] ^ x2[n+1] ^ x2[n];
    end
    for (int n = 0; n < CLEN; n++) cseq[n] = x1[n+1600] ^ x2[n+1600];
  endtask

  function automatic logic [7:0] model_ncs(input int ns, input int l);
    logic [7:0] v;
    for (int m = 0; m < 8; m++) v[m] = cseq[8*NSYMB*ns + 8*l + m];
    return v;
  endfunction

  // Upstream generator: restarts on o_cseq_start, advances one word per transfer.
  initial begin : upstream
    bit xfer, restart, tog;
    tog = 1'b0;
    forever begin
      @(negedge clk);
      xfer    = i_cseq_valid && o_cseq_get;
      restart = o_cseq_start;
      @(posedge clk);
      #1;
      if (restart) up_ptr = 0;
      else if (xfer) begin
        up_ptr   = up_ptr + NGEN;
        up_words = up_words + 1;
      end
      tog = !tog;
      i_cseq_valid = up_gap ? tog : 1'b1;
      for (int b = 0; b < NGEN; b++) i_cseq_bit[b] = cseq[(up_ptr + b) % CLEN];
    end
  end

  // One full request; use_tbl selects the hand table (n_ID=512, n_s=3) over the model.
  task automatic run_slot(input string tag, input int nid, input int ns, input bit gaps,
                          input int stall, input bit poke, input bit use_tbl);
    int cyc, beats, dones, first, nominal;
    logic [7:0] exp_ncs;
    gen_cseq(31'(nid));
    up_gap   = gaps;
    up_words = 0;
    i_nid    = 10'(nid);
    i_slot   = 8'(ns);
    i_start  = 1'b1;
    step();
    i_start = 1'b0;
    check({tag, "_busy_t1"}, o_busy, 1);
    check({tag, "_start_t1"}, o_cseq_start, 1);
    check({tag, "_init"}, o_cseq_init, nid);
    check({tag, "_threshold"}, o_cseq_threshold, 8 * NSYMB * (ns + 1));
    nominal = 2 + (8 * NSYMB * ns + 8) / NGEN;
    cyc = 1; beats = 0; dones = 0; first = -1;
    while (dones == 0 && cyc < 1500) begin
      if (o_valid && first < 0) first = cyc;
      i_ready = !(first >= 0 && cyc < first + stall);
      if (poke && cyc == 50) begin
        i_start = 1'b1;
        i_nid   = 10'd1;
        i_slot  = 8'd0;
      end
      if (poke && cyc == 51) begin
        i_start = 1'b0;
        check({tag, "_ignore_start"}, o_cseq_start, 0);
      end
      if (stall > 0 && first >= 0 && cyc == first + 5) begin
        check({tag, "_hold_ncs"}, o_ncs, use_tbl ? ncs_tbl[0] : model_ncs(ns, 0));
        check({tag, "_hold_get"}, o_cseq_get, 0);
      end
      if (o_valid && i_ready && beats < NSYMB) begin
        exp_ncs = use_tbl ? 8'(ncs_tbl[beats]) : model_ncs(ns, beats);
        check({tag, "_ncs"}, o_ncs, exp_ncs);
        check({tag, "_sym"}, o_sym, beats);
`ifdef PUCCH_NCS_ALPHA_EN
        if (use_tbl) check({tag, "_alpha"}, o_alpha_idx, alpha_tbl[beats]);
`endif
        beats++;
      end
      if (o_done) begin
        dones++;
        check({tag, "_beats"}, beats, NSYMB);
        check({tag, "_busy_at_done"}, o_busy, 0);
      end else begin
        step();
        cyc++;
      end
    end
    i_ready = 1'b1;
    check({tag, "_done_seen"}, dones, 1);
    if (gaps) check({tag, "_first_delayed"}, first > nominal, 1);
    else      check({tag, "_first_valid_cyc"}, first, nominal);
    step();
    check({tag, "_done_once"}, o_done, 0);
    check({tag, "_idle_valid"}, o_valid, 0);
    up_gap = 1'b0;
  endtask

  initial begin : main
    int wait_cyc;
    rst = 1'b1;
    repeat (3) step();
    check("rst_start", o_cseq_start, 0);
    check("rst_get", o_cseq_get, 0);
    check("rst_valid", o_valid, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_ncs", o_ncs, 0);
    check("rst_sym", o_sym, 0);
    check("rst_init", o_cseq_init, 0);
    check("rst_threshold", o_cseq_threshold, 0);
    rst = 1'b0;
    repeat (2) step();

    run_slot("nominal", 512, 3, 1'b0, 0, 1'b1, 1'b1);

    run_slot("slot0", 77, 0, 1'b0, 0, 1'b0, 1'b0);
    check("slot0_words", up_words, 8 * NSYMB / NGEN);

    run_slot("backpressure", 512, 3, 1'b0, 10, 1'b0, 1'b1);

    run_slot("gaps", 512, 3, 1'b1, 0, 1'b0, 1'b1);

    // Abort mid-COLLECT, then a fresh request must complete cleanly.
    gen_cseq(31'd512);
    i_nid   = 10'd512;
    i_slot  = 8'd0;
    i_start = 1'b1;
    step();
    i_start  = 1'b0;
    wait_cyc = 0;
    while (!o_valid && wait_cyc < 50) begin
      step();
      wait_cyc++;
    end
    check("abort_reached_collect", o_valid, 1);
    rst = 1'b1;
    step();
    check("abort_valid", o_valid, 0);
    check("abort_busy", o_busy, 0);
    check("abort_ncs", o_ncs, 0);
    rst = 1'b0;
    step();

    run_slot("after_abort", 512, 3, 1'b0, 0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
